// File: rtl/tcdm_req_decoder.sv
// Decodes scrambled TCDM addresses into tile/bank/row, buffers them in a 2-entry FIFO and bounds in-flight requests with credits.
// Latency 1 cycle; req_ready_o drops when the FIFO is full or credits run out. Optional macro: TCDM_DECODER_ERR_EN.
module tcdm_req_decoder #(
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned DataWidth       = 32,
  parameter int unsigned ByteOffset      = 2,
  parameter int unsigned NumTiles        = 2,
  parameter int unsigned NumBanksPerTile = 2,
  parameter int unsigned RowWidth        = 10,
  parameter int unsigned MaxOutstanding  = 4,
  parameter int unsigned TileBits        = $clog2(NumTiles),
  parameter int unsigned BankBits        = $clog2(NumBanksPerTile),
  parameter int unsigned BeWidth         = DataWidth / 8,
  parameter int unsigned CntWidth        = $clog2(MaxOutstanding + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [TileBits-1:0]   tile_id_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [AddrWidth-1:0]  req_addr_i,
  input  logic                  req_wen_i,
  input  logic [DataWidth-1:0]  req_wdata_i,
  input  logic [BeWidth-1:0]    req_be_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [TileBits-1:0]   out_tile_o,
  output logic [BankBits-1:0]   out_bank_o,
  output logic [RowWidth-1:0]   out_row_o,
  output logic                  out_local_o,
  output logic                  out_wen_o,
  output logic [DataWidth-1:0]  out_wdata_o,
  output logic [BeWidth-1:0]    out_be_o,
  input  logic                  rsp_valid_i,
  output logic [CntWidth-1:0]   inflight_o
`ifdef TCDM_DECODER_ERR_EN
  ,
  output logic                  err_o
`endif
);

  localparam int unsigned L1Bits = ByteOffset + BankBits + TileBits + RowWidth;
  localparam logic [CntWidth-1:0] MaxOut = CntWidth'(MaxOutstanding);

  typedef struct packed {
    logic [TileBits-1:0]  tile;
    logic [BankBits-1:0]  bank;
    logic [RowWidth-1:0]  row;
    logic                 lcl;
    logic                 wen;
    logic [DataWidth-1:0] wdata;
    logic [BeWidth-1:0]   be;
  } entry_t;

  entry_t              mem_q [2];
  entry_t              in_entry;
  entry_t              head;
  logic                wptr_q, rptr_q;
  logic [1:0]          count_q, count_d;
  logic [CntWidth-1:0] inflight_q, inflight_d;
  logic                full, req_fire, oor, push, pop, dec;
  logic                unused_addr;

  // Byte-offset bits never address a bank; high bits only matter for the range check.
  assign unused_addr = ^{req_addr_i[AddrWidth-1:L1Bits], req_addr_i[ByteOffset-1:0]};

`ifdef TCDM_DECODER_ERR_EN
  assign oor = |req_addr_i[AddrWidth-1:L1Bits];
`else
  assign oor = 1'b0;
`endif

  always_comb begin
    in_entry       = '0;
    in_entry.bank  = req_addr_i[ByteOffset +: BankBits];
    in_entry.tile  = req_addr_i[ByteOffset+BankBits +: TileBits];
    in_entry.row   = req_addr_i[ByteOffset+BankBits+TileBits +: RowWidth];
    in_entry.lcl   = (req_addr_i[ByteOffset+BankBits +: TileBits] == tile_id_i);
    in_entry.wen   = req_wen_i;
    in_entry.wdata = req_wdata_i;
    in_entry.be    = req_be_i;
  end

  assign full        = (count_q == 2'd2);
  assign req_ready_o = ~full & (inflight_q < MaxOut);
  assign req_fire    = req_valid_i & req_ready_o;
  assign push        = req_fire & ~oor;
  assign out_valid_o = (count_q != 2'd0);
  assign pop         = out_valid_o & out_ready_i;
  // A response with nothing in flight is dropped so the counter cannot wrap.
  assign dec         = rsp_valid_i & (inflight_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({push, dec})
      2'b10:   inflight_d = inflight_q + CntWidth'(1);
      2'b01:   inflight_d = inflight_q - CntWidth'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= in_entry;
        wptr_q        <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  assign head        = mem_q[rptr_q];
  assign out_tile_o  = head.tile;
  assign out_bank_o  = head.bank;
  assign out_row_o   = head.row;
  assign out_local_o = head.lcl;
  assign out_wen_o   = head.wen;
  assign out_wdata_o = head.wdata;
  assign out_be_o    = head.be;
  assign inflight_o  = inflight_q;

`ifdef TCDM_DECODER_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= req_fire & oor;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_tcdm_req_decoder.sv
// Directed bench for tcdm_req_decoder: decode table plus FIFO, credit, reset and error sequences.
module tb_tcdm_req_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tile_id = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_wen = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_tile;
  logic        out_bank;
  logic [9:0]  out_row;
  logic        out_local;
  logic        out_wen;
  logic [31:0] out_wdata;
  logic [3:0]  out_be;
  logic        rsp_valid = 1'b0;
  logic [2:0]  inflight;
`ifdef TCDM_DECODER_ERR_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  tcdm_req_decoder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .tile_id_i   (tile_id),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_wen_i   (req_wen),
    .req_wdata_i (req_wdata),
    .req_be_i    (req_be),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_tile_o  (out_tile),
    .out_bank_o  (out_bank),
    .out_row_o   (out_row),
    .out_local_o (out_local),
    .out_wen_o   (out_wen),
    .out_wdata_o (out_wdata),
    .out_be_o    (out_be),
    .rsp_valid_i (rsp_valid),
    .inflight_o  (inflight)
`ifdef TCDM_DECODER_ERR_EN
    ,
    .err_o       (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        tid;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        et;
    logic        eb;
    logic [9:0]  er;
    logic        el;
  } vec_t;

  vec_t vecs[$];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vecs.push_back('{32'h0000_001C, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 10'd1,   1'b1});
    vecs.push_back('{32'h0000_0000, 1'b0, 1'b0, 32'h0123_4567, 4'h1, 1'b0, 1'b0, 10'd0,   1'b1});
    vecs.push_back('{32'h0000_0004, 1'b1, 1'b1, 32'hA5A5_5A5A, 4'h3, 1'b0, 1'b1, 10'd0,   1'b0});
    vecs.push_back('{32'h0000_0008, 1'b0, 1'b0, 32'hFFFF_0000, 4'hC, 1'b1, 1'b0, 10'd0,   1'b0});
    vecs.push_back('{32'h0000_3FFC, 1'b1, 1'b1, 32'h8000_0001, 4'h8, 1'b1, 1'b1, 10'h3FF, 1'b1});
`ifndef TCDM_DECODER_ERR_EN
    // Bits above the L1 size alias back into the array.
    vecs.push_back('{32'h0001_0010, 1'b0, 1'b1, 32'h1111_2222, 4'h5, 1'b0, 1'b0, 10'd1,   1'b1});
    vecs.push_back('{32'hFFFF_C018, 1'b0, 1'b0, 32'h3333_4444, 4'hA, 1'b1, 1'b0, 10'd1,   1'b0});
`endif

    #12 rst_n = 1'b1;
    step();
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset inflight", 64'(inflight), 64'd0);
    check("reset out_row", 64'(out_row), 64'd0);
    check("reset out_wdata", 64'(out_wdata), 64'd0);
    check("reset req_ready", 64'(req_ready), 64'd1);
`ifdef TCDM_DECODER_ERR_EN
    check("reset err", 64'(err), 64'd0);
`endif

    // Decode table: one request at a time, drained and credited back.
    foreach (vecs[i]) begin
      tile_id   = vecs[i].tid;
      req_addr  = vecs[i].addr;
      req_wen   = vecs[i].wen;
      req_wdata = vecs[i].wdata;
      req_be    = vecs[i].be;
      req_valid = 1'b1;
      check($sformatf("vec%0d ready", i), 64'(req_ready), 64'd1);
      check($sformatf("vec%0d no comb path", i), 64'(out_valid), 64'd0);
      step();
      req_valid = 1'b0;
      check($sformatf("vec%0d valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d tile", i), 64'(out_tile), 64'(vecs[i].et));
      check($sformatf("vec%0d bank", i), 64'(out_bank), 64'(vecs[i].eb));
      check($sformatf("vec%0d row", i), 64'(out_row), 64'(vecs[i].er));
      check($sformatf("vec%0d local", i), 64'(out_local), 64'(vecs[i].el));
      check($sformatf("vec%0d wen", i), 64'(out_wen), 64'(vecs[i].wen));
      check($sformatf("vec%0d wdata", i), 64'(out_wdata), 64'(vecs[i].wdata));
      check($sformatf("vec%0d be", i), 64'(out_be), 64'(vecs[i].be));
      check($sformatf("vec%0d inflight", i), 64'(inflight), 64'd1);
      out_ready = 1'b1;
      rsp_valid = 1'b1;
      step();
      out_ready = 1'b0;
      rsp_valid = 1'b0;
      check($sformatf("vec%0d drained", i), 64'(out_valid), 64'd0);
      check($sformatf("vec%0d credit back", i), 64'(inflight), 64'd0);
    end

    // FIFO full: 2 of 3 accepted while downstream stalls.
    tile_id   = 1'b0;
    req_wen   = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h50;
    check("fifo ready 1st", 64'(req_ready), 64'd1);
    step();
    req_addr = 32'h60;
    check("fifo ready 2nd", 64'(req_ready), 64'd1);
    step();
    req_addr = 32'h70;
    check("fifo ready 3rd", 64'(req_ready), 64'd0);
    check("fifo inflight 2", 64'(inflight), 64'd2);
    step();
    check("fifo head stable", 64'(out_row), 64'd5);
    check("fifo still full", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    check("ready ignores valid", 64'(req_ready), 64'd0);
    out_ready = 1'b1;
    step();
    check("fifo order valid", 64'(out_valid), 64'd1);
    check("fifo order row", 64'(out_row), 64'd6);
    step();
    check("fifo empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    rsp_valid = 1'b1;
    step();
    step();
    check("fifo credits back", 64'(inflight), 64'd0);
    step();
    rsp_valid = 1'b0;
    check("rsp at zero saturates", 64'(inflight), 64'd0);

    // Credit limit with a free-flowing downstream.
    out_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'(i * 16);
      check($sformatf("credit accept %0d", i), 64'(req_ready), 64'd1);
      step();
    end
    check("credit 5th stalls", 64'(req_ready), 64'd0);
    check("credit inflight 4", 64'(inflight), 64'd4);
    step();
    check("credit still stalled", 64'(req_ready), 64'd0);
    rsp_valid = 1'b1;
    step();
    rsp_valid = 1'b0;
    check("credit released", 64'(req_ready), 64'd1);
    check("credit inflight 3", 64'(inflight), 64'd3);
    step();
    req_valid = 1'b0;
    check("credit 5th taken", 64'(inflight), 64'd4);
    rsp_valid = 1'b1;
    step();
    check("credit back to 3", 64'(inflight), 64'd3);
    req_valid = 1'b1;
    check("credit same-cycle ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    check("credit same-cycle holds", 64'(inflight), 64'd3);
    step();
    step();
    step();
    rsp_valid = 1'b0;
    check("credit drained", 64'(inflight), 64'd0);
    out_ready = 1'b0;

    // Async reset with two entries buffered.
    req_valid = 1'b1;
    req_addr  = 32'h70;
    step();
    req_addr = 32'h80;
    step();
    req_valid = 1'b0;
    check("pre-reset valid", 64'(out_valid), 64'd1);
    check("pre-reset inflight", 64'(inflight), 64'd2);
    rst_n = 1'b0;
    #1;
    check("async reset valid", 64'(out_valid), 64'd0);
    check("async reset inflight", 64'(inflight), 64'd0);
    check("async reset row", 64'(out_row), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    req_valid = 1'b1;
    req_addr  = 32'h90;
    out_ready = 1'b1;
    step();
    req_valid = 1'b0;
    check("post-reset latency", 64'(out_valid), 64'd1);
    check("post-reset row", 64'(out_row), 64'd9);
    rsp_valid = 1'b1;
    step();
    rsp_valid = 1'b0;
    check("post-reset drained", 64'(out_valid), 64'd0);
    check("post-reset inflight", 64'(inflight), 64'd0);

`ifdef TCDM_DECODER_ERR_EN
    // Out-of-range request: accepted, flagged, never enqueued.
    req_valid = 1'b1;
    req_addr  = 32'h0001_0000;
    check("err ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    check("err pulse", 64'(err), 64'd1);
    check("err no enqueue", 64'(out_valid), 64'd0);
    check("err no credit", 64'(inflight), 64'd0);
    step();
    check("err one cycle", 64'(err), 64'd0);
    req_valid = 1'b1;
    req_addr  = 32'h0000_001C;
    step();
    req_valid = 1'b0;
    check("err clean request", 64'(err), 64'd0);
    check("err clean valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
